ftq: RTL and testbench

Fetch Target Queue between the branch predictor (uBTB/FTB stage) and the icache.
- Buffers predicted fetch blocks (BPInfo_t) from the predictor.
- Hands them in order to the icache as ftq2icacheInfo_t.
- Retires them in order on backend commit, emitting one registered BPupdateInfo_t per committed block for predictor training.
- A backend squash discards every entry younger than a given queue index.

---
 rtl/ftq_pkg.sv | 36 +++
 rtl/ftq.sv | 138 +++++++++++++
 tb/tb_ftq.sv | 360 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ftq_pkg.sv
// Shared payload types for the predictor -> ftq -> icache path and the training return path.
package ftq_pkg;
    localparam int XLEN              = 32;
    localparam int FTB_PREDICT_WIDTH = 16;
    localparam int SIZEW             = $clog2(FTB_PREDICT_WIDTH + 1);

    typedef logic [XLEN-1:0] addr_t;

    typedef struct packed {
        addr_t      startAddr;
        addr_t      endAddr;
        addr_t      nextAddr;
        logic       taken;
        logic [1:0] branch_type;
        logic       hit_on_ubtb;
        logic       hit_on_ftb;
    } BPInfo_t;

    typedef struct packed {
        addr_t            startAddr;
        addr_t            nextAddr;
        logic             taken;
        logic [SIZEW-1:0] fetchBlock_size;
    } ftq2icacheInfo_t;

    typedef struct packed {
        addr_t      startAddr;
        addr_t      fallthruAddr;
        addr_t      targetAddr;
        logic [1:0] branch_type;
        logic       taken;
        logic       mispred;
        logic       hit_on_ubtb;
        logic       hit_on_ftb;
    } BPupdateInfo_t;
endpackage

// File: rtl/ftq.sv
// Fetch target queue: buffers predicted blocks, feeds the icache in order, retires on commit.
// Latency: enqueued block fetchable next cycle; training update registered one cycle after commit.
// Backpressure: o_bp_rdy low when full; fetch holds while i_fetch_rdy low; squash drops same-cycle enqueue.
module ftq
    import ftq_pkg::*;
#(
    parameter int FTQ_SIZE = 8,
    parameter int IDXW     = $clog2(FTQ_SIZE)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_bp_vld,
    input  BPInfo_t             i_bp_info,
    output logic                o_bp_rdy,
    output logic                o_fetch_vld,
    output ftq2icacheInfo_t     o_fetch_info,
    output logic [IDXW-1:0]     o_fetch_ftqIdx,
    input  logic                i_fetch_rdy,
    input  logic                i_commit_vld,
    input  logic                i_commit_taken,
    input  logic                i_commit_mispred,
    input  logic [XLEN-1:0]     i_commit_targetAddr,
    input  logic                i_squash_vld,
    input  logic [IDXW-1:0]     i_squash_ftqIdx,
    output logic                o_bpupdate_vld,
    output BPupdateInfo_t       o_bpupdate_info
);
    typedef logic [IDXW:0] ptr_t;

    BPInfo_t         r_entry [FTQ_SIZE];
    ptr_t            r_enq_ptr;
    ptr_t            r_fetch_ptr;
    ptr_t            r_commit_ptr;
    logic            r_bpupdate_vld;
    BPupdateInfo_t   r_bpupdate_info;

    ptr_t            w_enq_nxt;
    ptr_t            w_fetch_nxt;
    ptr_t            w_commit_nxt;
    ptr_t            w_surv;
    ptr_t            w_fetch_adv;
    ptr_t            w_fetch_dist;
    logic [IDXW-1:0] w_surv_m1;
    logic [IDXW-1:0] w_fidx;
    logic [IDXW-1:0] w_cidx;
    logic [SIZEW:0]  w_span;
    logic            w_full;
    logic            w_enq;
    logic            w_fetch_hs;
    logic            w_commit;

    assign w_fidx      = r_fetch_ptr[IDXW-1:0];
    assign w_cidx      = r_commit_ptr[IDXW-1:0];
    assign w_full      = (r_enq_ptr[IDXW-1:0] == w_cidx) && (r_enq_ptr[IDXW] != r_commit_ptr[IDXW]);
    assign o_bp_rdy    = !w_full;
    assign o_fetch_vld = (r_fetch_ptr != r_enq_ptr);
    assign w_enq       = i_bp_vld && o_bp_rdy && !i_squash_vld;
    assign w_fetch_hs  = o_fetch_vld && i_fetch_rdy;
    assign w_commit    = i_commit_vld && (r_commit_ptr != r_fetch_ptr);

    // Survivors counted from the pre-commit head, so a same-cycle commit can empty the queue.
    assign w_surv_m1    = i_squash_ftqIdx - w_cidx;
    assign w_surv       = {1'b0, w_surv_m1} + ptr_t'(1);
    assign w_fetch_adv  = r_fetch_ptr + ptr_t'(w_fetch_hs);
    assign w_fetch_dist = w_fetch_adv - r_commit_ptr;

    always_comb begin
        w_enq_nxt    = r_enq_ptr;
        w_fetch_nxt  = w_fetch_adv;
        w_commit_nxt = r_commit_ptr + ptr_t'(w_commit);
        if (i_squash_vld) begin
            w_enq_nxt = r_commit_ptr + w_surv;
            if (w_fetch_dist > w_surv) begin
                w_fetch_nxt = r_commit_ptr + w_surv;
            end
        end else if (w_enq) begin
            w_enq_nxt = r_enq_ptr + ptr_t'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_enq_ptr    <= '0;
            r_fetch_ptr  <= '0;
            r_commit_ptr <= '0;
        end else begin
            r_enq_ptr    <= w_enq_nxt;
            r_fetch_ptr  <= w_fetch_nxt;
            r_commit_ptr <= w_commit_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_entry[r_enq_ptr[IDXW-1:0]] <= i_bp_info;
        end
    end

    // Low bits of the difference depend only on low bits of the operands.
    assign w_span = r_entry[w_fidx].endAddr[SIZEW:0] - r_entry[w_fidx].startAddr[SIZEW:0];

    always_comb begin
        o_fetch_info                 = '0;
        o_fetch_info.startAddr       = r_entry[w_fidx].startAddr;
        o_fetch_info.nextAddr        = r_entry[w_fidx].nextAddr;
        o_fetch_info.taken           = r_entry[w_fidx].taken;
        o_fetch_info.fetchBlock_size = SIZEW'(w_span >> 1);
    end

    assign o_fetch_ftqIdx = w_fidx;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_bpupdate_vld  <= 1'b0;
            r_bpupdate_info <= '0;
        end else begin
            r_bpupdate_vld <= w_commit;
            if (w_commit) begin
                r_bpupdate_info.startAddr    <= r_entry[w_cidx].startAddr;
                r_bpupdate_info.fallthruAddr <= r_entry[w_cidx].endAddr;
                r_bpupdate_info.targetAddr   <= i_commit_targetAddr;
                r_bpupdate_info.branch_type  <= r_entry[w_cidx].branch_type;
                r_bpupdate_info.taken        <= i_commit_taken;
                r_bpupdate_info.mispred      <= i_commit_mispred;
                r_bpupdate_info.hit_on_ubtb  <= r_entry[w_cidx].hit_on_ubtb;
                r_bpupdate_info.hit_on_ftb   <= r_entry[w_cidx].hit_on_ftb;
            end
        end
    end

    assign o_bpupdate_vld  = r_bpupdate_vld;
    assign o_bpupdate_info = r_bpupdate_info;

    a_commit_legal: assert property (@(posedge clk) disable iff (!rst)
        i_commit_vld |-> (r_commit_ptr != r_fetch_ptr));
    a_squash_range: assert property (@(posedge clk) disable iff (!rst)
        i_squash_vld |-> ({1'b0, w_surv_m1} < (r_enq_ptr - r_commit_ptr)));
endmodule

// File: tb/tb_ftq.sv
// Bench for ftq: directed sequences, a size/commit vector table, and randomized traffic against a queue model.
module tb_ftq;
    import ftq_pkg::*;

    localparam int N  = 8;
    localparam int IW = 3;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            i_bp_vld;
    BPInfo_t         i_bp_info;
    logic            o_bp_rdy;
    logic            o_fetch_vld;
    ftq2icacheInfo_t o_fetch_info;
    logic [IW-1:0]   o_fetch_ftqIdx;
    logic            i_fetch_rdy;
    logic            i_commit_vld;
    logic            i_commit_taken;
    logic            i_commit_mispred;
    logic [XLEN-1:0] i_commit_targetAddr;
    logic            i_squash_vld;
    logic [IW-1:0]   i_squash_ftqIdx;
    logic            o_bpupdate_vld;
    BPupdateInfo_t   o_bpupdate_info;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ftq #(.FTQ_SIZE(N)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .i_bp_vld            (i_bp_vld),
        .i_bp_info           (i_bp_info),
        .o_bp_rdy            (o_bp_rdy),
        .o_fetch_vld         (o_fetch_vld),
        .o_fetch_info        (o_fetch_info),
        .o_fetch_ftqIdx      (o_fetch_ftqIdx),
        .i_fetch_rdy         (i_fetch_rdy),
        .i_commit_vld        (i_commit_vld),
        .i_commit_taken      (i_commit_taken),
        .i_commit_mispred    (i_commit_mispred),
        .i_commit_targetAddr (i_commit_targetAddr),
        .i_squash_vld        (i_squash_vld),
        .i_squash_ftqIdx     (i_squash_ftqIdx),
        .o_bpupdate_vld      (o_bpupdate_vld),
        .o_bpupdate_info     (o_bpupdate_info)
    );

    typedef struct {
        logic [31:0] sa;
        logic [31:0] ea;
        logic [4:0]  sz;
        logic        tk;
        logic        mp;
        logic [31:0] tgt;
    } vec_t;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        i_bp_vld            = 1'b0;
        i_bp_info           = '0;
        i_fetch_rdy         = 1'b0;
        i_commit_vld        = 1'b0;
        i_commit_taken      = 1'b0;
        i_commit_mispred    = 1'b0;
        i_commit_targetAddr = '0;
        i_squash_vld        = 1'b0;
        i_squash_ftqIdx     = '0;
    endtask

    function automatic BPInfo_t mk(input logic [31:0] sa, input logic [31:0] ea);
        mk           = '0;
        mk.startAddr = sa;
        mk.endAddr   = ea;
        mk.nextAddr  = ea;
    endfunction

    function automatic BPInfo_t rand_info();
        rand_info             = '0;
        rand_info.startAddr   = $urandom & 32'hffff_fffe;
        rand_info.endAddr     = rand_info.startAddr + 32'(2 * $urandom_range(0, 16));
        rand_info.nextAddr    = $urandom;
        rand_info.taken       = 1'($urandom);
        rand_info.branch_type = 2'($urandom);
        rand_info.hit_on_ubtb = 1'($urandom);
        rand_info.hit_on_ftb  = 1'($urandom);
    endfunction

    function automatic ftq2icacheInfo_t exp_fetch(input BPInfo_t e);
        exp_fetch                 = '0;
        exp_fetch.startAddr       = e.startAddr;
        exp_fetch.nextAddr        = e.nextAddr;
        exp_fetch.taken           = e.taken;
        exp_fetch.fetchBlock_size = SIZEW'((e.endAddr - e.startAddr) / 2);
    endfunction

    task automatic reset_pulse_check(input string tag);
        rst = 1'b0;
        #1;
        chk({tag, "_bp_rdy"}, 128'(o_bp_rdy), 128'(1));
        chk({tag, "_fetch_vld"}, 128'(o_fetch_vld), 128'(0));
        chk({tag, "_upd_vld"}, 128'(o_bpupdate_vld), 128'(0));
        chk({tag, "_upd_info"}, 128'(o_bpupdate_info), 128'(0));
        #2 rst = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t            vt[5];
        BPInfo_t         mq[$];
        int              nf;
        int              head;
        int              s;
        logic            hs;
        logic            exp_uv;
        BPupdateInfo_t   exp_ui;
        BPupdateInfo_t   eu;
        ftq2icacheInfo_t ef;

        vt[0] = '{32'h1000, 32'h1010, 5'd8,  1'b1, 1'b1, 32'h2000};
        vt[1] = '{32'h1000, 32'h1002, 5'd1,  1'b0, 1'b0, 32'h1002};
        vt[2] = '{32'h3000, 32'h3000, 5'd0,  1'b1, 1'b0, 32'h3400};
        vt[3] = '{32'h4000, 32'h4020, 5'd16, 1'b0, 1'b1, 32'h4020};
        vt[4] = '{32'h5ffe, 32'h6004, 5'd3,  1'b1, 1'b1, 32'h0abc};

        idle();
        #1 rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        chk("rst_bp_rdy", 128'(o_bp_rdy), 128'(1));
        chk("rst_fetch_vld", 128'(o_fetch_vld), 128'(0));
        chk("rst_upd_vld", 128'(o_bpupdate_vld), 128'(0));
        chk("rst_upd_info", 128'(o_bpupdate_info), 128'(0));

        // Fill eight, try a ninth, then drain fetch in order.
        for (int k = 0; k < 8; k++) begin
            i_bp_vld  = 1'b1;
            i_bp_info = mk(32'h1000 + 32'(k) * 32'h100, 32'h1010 + 32'(k) * 32'h100);
            chk("fill_rdy", 128'(o_bp_rdy), 128'(1));
            tick();
        end
        chk("full_rdy", 128'(o_bp_rdy), 128'(0));
        i_bp_info = mk(32'hdead_0000, 32'hdead_0010);
        tick();
        i_bp_vld = 1'b0;
        for (int k = 0; k < 8; k++) begin
            chk("drain_vld", 128'(o_fetch_vld), 128'(1));
            chk("drain_idx", 128'(o_fetch_ftqIdx), 128'(k));
            chk("drain_start", 128'(o_fetch_info.startAddr), 128'(32'h1000 + 32'(k) * 32'h100));
            i_fetch_rdy = 1'b1;
            tick();
            i_fetch_rdy = 1'b0;
        end
        chk("drained_vld", 128'(o_fetch_vld), 128'(0));
        chk("drained_rdy", 128'(o_bp_rdy), 128'(0));

        // Full queue: commit and enqueue together, enqueue must wait a cycle.
        i_commit_vld = 1'b1;
        i_bp_vld     = 1'b1;
        i_bp_info    = mk(32'h5000, 32'h5008);
        tick();
        i_commit_vld = 1'b0;
        chk("fullce_upd_vld", 128'(o_bpupdate_vld), 128'(1));
        chk("fullce_upd_start", 128'(o_bpupdate_info.startAddr), 128'(32'h1000));
        chk("fullce_rdy", 128'(o_bp_rdy), 128'(1));
        chk("fullce_fetch_vld", 128'(o_fetch_vld), 128'(0));
        tick();
        i_bp_vld = 1'b0;
        chk("fullce_retry_vld", 128'(o_fetch_vld), 128'(1));
        chk("fullce_retry_idx", 128'(o_fetch_ftqIdx), 128'(0));
        chk("fullce_retry_start", 128'(o_fetch_info.startAddr), 128'(32'h5000));
        chk("fullce_retry_rdy", 128'(o_bp_rdy), 128'(0));
        chk("fullce_pulse_end", 128'(o_bpupdate_vld), 128'(0));
        i_fetch_rdy  = 1'b1;
        i_commit_vld = 1'b1;
        repeat (8) tick();
        idle();
        chk("empty_rdy", 128'(o_bp_rdy), 128'(1));
        chk("empty_fetch_vld", 128'(o_fetch_vld), 128'(0));
        reset_pulse_check("midrst1");

        // Squash: six enqueued, four fetched, keep idx 0..1.
        for (int k = 0; k < 6; k++) begin
            i_bp_vld  = 1'b1;
            i_bp_info = mk(32'h6000 + 32'(k) * 32'h10, 32'h6008 + 32'(k) * 32'h10);
            tick();
        end
        i_bp_vld    = 1'b0;
        i_fetch_rdy = 1'b1;
        repeat (4) tick();
        i_fetch_rdy = 1'b0;
        chk("sq_pre_idx", 128'(o_fetch_ftqIdx), 128'(4));
        i_squash_vld    = 1'b1;
        i_squash_ftqIdx = 3'd1;
        i_bp_vld        = 1'b1;
        i_bp_info       = mk(32'hbad0_0000, 32'hbad0_0008);
        tick();
        idle();
        chk("sq_fetch_vld", 128'(o_fetch_vld), 128'(0));
        chk("sq_rdy", 128'(o_bp_rdy), 128'(1));
        i_bp_vld  = 1'b1;
        i_bp_info = mk(32'h7000, 32'h7008);
        tick();
        i_bp_vld = 1'b0;
        chk("sq_new_vld", 128'(o_fetch_vld), 128'(1));
        chk("sq_new_idx", 128'(o_fetch_ftqIdx), 128'(2));
        chk("sq_new_start", 128'(o_fetch_info.startAddr), 128'(32'h7000));
        i_fetch_rdy = 1'b1;
        tick();
        i_fetch_rdy = 1'b0;
        // Squash keeping only the entry being committed: queue empties.
        i_commit_vld    = 1'b1;
        i_squash_vld    = 1'b1;
        i_squash_ftqIdx = 3'd0;
        tick();
        idle();
        chk("sqc_upd_vld", 128'(o_bpupdate_vld), 128'(1));
        chk("sqc_upd_start", 128'(o_bpupdate_info.startAddr), 128'(32'h6000));
        chk("sqc_fetch_vld", 128'(o_fetch_vld), 128'(0));
        chk("sqc_rdy", 128'(o_bp_rdy), 128'(1));
        i_bp_vld  = 1'b1;
        i_bp_info = mk(32'h7100, 32'h7108);
        tick();
        i_bp_vld = 1'b0;
        chk("sqc_new_idx", 128'(o_fetch_ftqIdx), 128'(1));
        chk("sqc_new_vld", 128'(o_fetch_vld), 128'(1));
        i_fetch_rdy = 1'b1;
        tick();
        idle();
        i_commit_vld = 1'b1;
        tick();
        idle();

        // Vector table: fetch size and training payload.
        for (int k = 0; k < 5; k++) begin
            i_bp_vld  = 1'b1;
            i_bp_info = mk(vt[k].sa, vt[k].ea);
            tick();
            i_bp_vld = 1'b0;
            ef                 = '0;
            ef.startAddr       = vt[k].sa;
            ef.nextAddr        = vt[k].ea;
            ef.fetchBlock_size = vt[k].sz;
            chk("vec_fetch_vld", 128'(o_fetch_vld), 128'(1));
            chk("vec_fetch_info", 128'(o_fetch_info), 128'(ef));
            i_fetch_rdy = 1'b1;
            tick();
            i_fetch_rdy         = 1'b0;
            i_commit_vld        = 1'b1;
            i_commit_taken      = vt[k].tk;
            i_commit_mispred    = vt[k].mp;
            i_commit_targetAddr = vt[k].tgt;
            tick();
            idle();
            eu              = '0;
            eu.startAddr    = vt[k].sa;
            eu.fallthruAddr = vt[k].ea;
            eu.targetAddr   = vt[k].tgt;
            eu.taken        = vt[k].tk;
            eu.mispred      = vt[k].mp;
            chk("vec_upd_vld", 128'(o_bpupdate_vld), 128'(1));
            chk("vec_upd_info", 128'(o_bpupdate_info), 128'(eu));
            tick();
            chk("vec_upd_pulse", 128'(o_bpupdate_vld), 128'(0));
        end

        // Randomized traffic against a queue model, with a reset mid-stream.
        reset_pulse_check("rst2");
        mq.delete();
        nf     = 0;
        head   = 0;
        exp_uv = 1'b0;
        exp_ui = '0;
        tick();
        for (int cyc = 0; cyc < 700; cyc++) begin
            if (cyc == 350) begin
                reset_pulse_check("midrst2");
                mq.delete();
                nf     = 0;
                head   = 0;
                exp_uv = 1'b0;
            end
            chk("rnd_rdy", 128'(o_bp_rdy), 128'(mq.size() < N));
            chk("rnd_fetch_vld", 128'(o_fetch_vld), 128'(nf < mq.size()));
            if (nf < mq.size()) begin
                chk("rnd_fetch_idx", 128'(o_fetch_ftqIdx), 128'((head + nf) % N));
                chk("rnd_fetch_info", 128'(o_fetch_info), 128'(exp_fetch(mq[nf])));
            end
            chk("rnd_upd_vld", 128'(o_bpupdate_vld), 128'(exp_uv));
            if (exp_uv) begin
                chk("rnd_upd_info", 128'(o_bpupdate_info), 128'(exp_ui));
            end

            i_bp_vld            = ($urandom_range(0, 99) < 60);
            i_bp_info           = rand_info();
            i_fetch_rdy         = ($urandom_range(0, 99) < 55);
            i_commit_vld        = (nf > 0) && ($urandom_range(0, 99) < 45);
            i_commit_taken      = 1'($urandom);
            i_commit_mispred    = 1'($urandom);
            i_commit_targetAddr = $urandom;
            i_squash_vld        = (mq.size() > 0) && ($urandom_range(0, 99) < 8);
            i_squash_ftqIdx     = '0;
            if (mq.size() > 0) begin
                i_squash_ftqIdx = IW'((head + int'($urandom_range(0, mq.size() - 1))) % N);
            end

            hs     = (nf < mq.size()) && i_fetch_rdy;
            exp_uv = i_commit_vld;
            if (i_commit_vld) begin
                exp_ui              = '0;
                exp_ui.startAddr    = mq[0].startAddr;
                exp_ui.fallthruAddr = mq[0].endAddr;
                exp_ui.targetAddr   = i_commit_targetAddr;
                exp_ui.branch_type  = mq[0].branch_type;
                exp_ui.taken        = i_commit_taken;
                exp_ui.mispred      = i_commit_mispred;
                exp_ui.hit_on_ubtb  = mq[0].hit_on_ubtb;
                exp_ui.hit_on_ftb   = mq[0].hit_on_ftb;
            end
            nf = nf + int'(hs);
            if (i_squash_vld) begin
                s = ((int'(i_squash_ftqIdx) - head + N) % N) + 1;
                while (mq.size() > s) void'(mq.pop_back());
                if (nf > s) nf = s;
            end else if (i_bp_vld && mq.size() < N) begin
                mq.push_back(i_bp_info);
            end
            if (i_commit_vld) begin
                void'(mq.pop_front());
                head = (head + 1) % N;
                nf   = nf - 1;
            end
            tick();
        end
        idle();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
